// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers and stream type for the FIFO read path
package fifo_pkg;

  localparam int STREAM_WIDTH = 16;

  typedef struct packed {
    logic                    valid;
    logic [STREAM_WIDTH-1:0] data;
  } stream_t;

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - RD_LAT-deep delay line of fifo_valid with occupancy count
module rd_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int CW     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_bit,
  output logic          out_bit,
  output logic [CW-1:0] count
);

  if (RD_LAT == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = clk ^ rst_n ^ flush;
    assign out_bit     = in_bit;
    assign count       = '0;
  end else begin : g_line
    logic [RD_LAT-1:0] line;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        line <= '0;
      end else if (flush) begin
        line <= '0;
      end else begin
        line <= RD_LAT'({line, in_bit});
      end
    end

    assign out_bit = line[RD_LAT-1];

    always_comb begin
      count = '0;
      for (int i = 0; i < RD_LAT; i++) begin
        count = count + CW'(line[i]);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_prefetch.sv
// rtl/fifo_rd_prefetch.sv - prefetching read stage turning FIFO pop/rdata into a valid/ready stream
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       fifo_empty,
  input  logic                       fifo_valid,
  input  logic [WIDTH-1:0]           fifo_rdata,
  output logic                       fifo_pop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int IW = clog2_min1(DEPTH);
  localparam int CW = clog2_min1(RD_LAT + 1);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = LW + 2;

  if (RD_LAT < 0 || RD_LAT > 3 || DEPTH < RD_LAT + 1) begin : g_bad_params
    $error("fifo_rd_prefetch: need 0 <= RD_LAT <= 3 and DEPTH >= RD_LAT+1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic [CW-1:0]    inflight;
  logic             arrive;
  logic             cap;
  logic             deq;
  logic             deq_eff;
  logic [SW-1:0]    credit;

  function automatic logic [IW-1:0] bump(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
  endfunction

  rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .CW     (CW)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_bit  (fifo_valid),
    .out_bit (arrive),
    .count   (inflight)
  );

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_idx];
  assign deq       = out_valid & out_ready;
  assign cap       = arrive & !flush;
  assign deq_eff   = deq & !flush;

  // Words owned or promised; a slot freed by this cycle's deq is reusable now.
  always_comb begin
    credit = SW'(level) + SW'(inflight) - SW'(deq);
  end

  // rst_n gates the pop so nothing is requested while the stage is held in reset.
  assign fifo_pop = rst_n & !flush & !fifo_empty & (credit < SW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
      wr_idx <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_idx <= '0;
      wr_idx <= '0;
      level  <= '0;
    end else begin
      if (cap) begin
        wr_idx <= bump(wr_idx);
      end
      if (deq_eff) begin
        rd_idx <= bump(rd_idx);
      end
      if (cap && !deq_eff) begin
        level <= level + LW'(1);
      end else if (!cap && deq_eff) begin
        level <= level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (cap) begin
      mem[wr_idx] <= fifo_rdata;
    end
  end

  always @(posedge clk) begin
    if (rst_n && cap && !deq_eff) begin
      a_no_overflow: assert (level != LW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// tb/tb_fifo_rd_prefetch.sv - directed and random checks of fifo_rd_prefetch for RD_LAT 0..3
module tb_fifo_rd_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  flush = '0;
  logic [3:0]  ready = '0;
  logic [3:0]  empty;
  logic [3:0]  vld;
  logic [3:0]  pop;
  logic [3:0]  ovalid;
  logic [15:0] rdata [4];
  logic [15:0] odata [4];
  logic [2:0]  lvl [4];

  int checks = 0;
  int errors = 0;
  int pop_empty = 0;
  int deliv [4] = '{default: 0};

  logic [15:0] fmem [4][64];
  int          fhead [4] = '{default: 0};
  int          fcount [4] = '{default: 0};
  logic [15:0] rpipe [4][3];
  logic [3:0]  push_req = '0;
  int          push_n [4] = '{default: 0};
  logic [15:0] push_val [4][64];
  logic [15:0] sbq [4][$];
  logic [3:0]  prev_stall = '0;
  logic [15:0] prev_data [4];

  always #5 clk = ~clk;

  // Lane g: RD_LAT = g, DEPTH = g + 1.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int LW = $clog2(g + 2);
    logic [LW-1:0] lv;
    fifo_rd_prefetch #(
      .WIDTH  (16),
      .RD_LAT (g),
      .DEPTH  (g + 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush[g]),
      .fifo_empty (empty[g]),
      .fifo_valid (vld[g]),
      .fifo_rdata (rdata[g]),
      .fifo_pop   (pop[g]),
      .out_valid  (ovalid[g]),
      .out_ready  (ready[g]),
      .out_data   (odata[g]),
      .level      (lv)
    );
    assign lvl[g] = 3'(lv);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      empty[k] = (fcount[k] == 0);
      vld[k]   = pop[k] & ~empty[k];
    end
  end

  assign rdata[0] = fmem[0][fhead[0]];
  assign rdata[1] = rpipe[1][0];
  assign rdata[2] = rpipe[2][1];
  assign rdata[3] = rpipe[3][2];

  // FIFO model per lane; its contents survive reset, popped-but-undelivered words do not.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) sbq[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        rpipe[k][0] <= vld[k] ? fmem[k][fhead[k]] : 16'hBAD0;
        rpipe[k][1] <= rpipe[k][0];
        rpipe[k][2] <= rpipe[k][1];
        if (vld[k]) sbq[k].push_back(fmem[k][fhead[k]]);
        if (push_req[k]) begin
          for (int i = 0; i < push_n[k]; i++) begin
            fmem[k][(fhead[k] + fcount[k] + i) % 64] <= push_val[k][i];
          end
        end
        fhead[k]  <= vld[k] ? (fhead[k] + 1) % 64 : fhead[k];
        fcount[k] <= fcount[k] - (vld[k] ? 1 : 0) + (push_req[k] ? push_n[k] : 0);
      end
    end
  end

  always begin : mon
    logic [15:0] want;
    @(negedge clk);
    #3;
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        prev_stall[k] = 1'b0;
      end else begin
        if (pop[k] && empty[k]) pop_empty++;
        if (prev_stall[k]) begin
          checks++;
          if (ovalid[k] !== 1'b1 || odata[k] !== prev_data[k]) begin
            errors++;
            $display("FAIL stall_hold lane %0d: valid %b data %h, required valid 1 data %h",
                     k, ovalid[k], odata[k], prev_data[k]);
          end
        end
        if (flush[k]) begin
          sbq[k].delete();
        end else if (ovalid[k] && ready[k]) begin
          checks++;
          deliv[k]++;
          if (sbq[k].size() == 0) begin
            errors++;
            $display("FAIL deliver lane %0d: got %h, required no word (none outstanding)", k, odata[k]);
          end else begin
            want = sbq[k].pop_front();
            if (odata[k] !== want) begin
              errors++;
              $display("FAIL deliver lane %0d: got %h, required %h", k, odata[k], want);
            end
          end
        end
        prev_stall[k] = ovalid[k] & ~ready[k] & ~flush[k];
        prev_data[k]  = odata[k];
      end
    end
  end

  task automatic push_words(input int lane, input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) push_val[lane][i] = first + 16'(i);
    push_n[lane]   = n;
    push_req[lane] = 1'b1;
    @(posedge clk);
    #1;
    push_req[lane] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pop[k] !== 1'b0) begin errors++; $display("FAIL reset_pop lane %0d: got %b, required 0", k, pop[k]); end
      checks++;
      if (ovalid[k] !== 1'b0) begin errors++; $display("FAIL reset_valid lane %0d: got %b, required 0", k, ovalid[k]); end
      checks++;
      if (odata[k] !== 16'h0) begin errors++; $display("FAIL reset_data lane %0d: got %h, required 0000", k, odata[k]); end
      checks++;
      if (lvl[k] !== 3'd0) begin errors++; $display("FAIL reset_level lane %0d: got %0d, required 0", k, lvl[k]); end
    end
  endtask

  task automatic test_stream();
    @(negedge clk);
    ready = 4'b0010;
    push_words(1, 16'h0001, 8);
    @(negedge clk); #1;
    checks++;
    if (pop[1] !== 1'b1 || ovalid[1] !== 1'b0) begin
      errors++; $display("FAIL stream_first_pop: pop %b valid %b, required pop 1 valid 0", pop[1], ovalid[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b0) begin errors++; $display("FAIL stream_latency: valid %b, required 0", ovalid[1]); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      checks++;
      if (ovalid[1] !== 1'b1 || odata[1] !== 16'(i + 1) || lvl[1] !== 3'd1) begin
        errors++;
        $display("FAIL stream_word %0d: valid %b data %h level %0d, required valid 1 data %h level 1",
                 i, ovalid[1], odata[1], lvl[1], 16'(i + 1));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b0 || lvl[1] !== 3'd0) begin
      errors++; $display("FAIL stream_end: valid %b level %0d, required valid 0 level 0", ovalid[1], lvl[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] want_l;
    @(negedge clk);
    ready = 4'b0000;
    push_words(1, 16'h0001, 8);
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (pop[1] !== 1'b1) begin errors++; $display("FAIL bp_second_pop: got %b, required 1", pop[1]); end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); #1;
      want_l = (j == 0) ? 3'd1 : 3'd2;
      checks++;
      if (ovalid[1] !== 1'b1 || odata[1] !== 16'h0001 || pop[1] !== 1'b0 || lvl[1] !== want_l) begin
        errors++;
        $display("FAIL bp_stall %0d: valid %b data %h pop %b level %0d, required valid 1 data 0001 pop 0 level %0d",
                 j, ovalid[1], odata[1], pop[1], lvl[1], want_l);
      end
    end
    @(negedge clk);
    ready = 4'b0010;
    #1;
    checks++;
    if (odata[1] !== 16'h0001 || pop[1] !== 1'b1 || lvl[1] !== 3'd2) begin
      errors++;
      $display("FAIL bp_release: data %h pop %b level %0d, required data 0001 pop 1 level 2", odata[1], pop[1], lvl[1]);
    end
    for (int v = 2; v <= 8; v++) begin
      @(negedge clk); #1;
      checks++;
      if (ovalid[1] !== 1'b1 || odata[1] !== 16'(v)) begin
        errors++; $display("FAIL bp_resume: valid %b data %h, required valid 1 data %h", ovalid[1], odata[1], 16'(v));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b0 || lvl[1] !== 3'd0) begin
      errors++; $display("FAIL bp_end: valid %b level %0d, required valid 0 level 0", ovalid[1], lvl[1]);
    end
  endtask

  task automatic test_empty_refill();
    @(negedge clk);
    ready = 4'b0010;
    push_words(1, 16'h00A1, 1);
    @(negedge clk); #1;
    checks++;
    if (pop[1] !== 1'b1) begin errors++; $display("FAIL refill_pop1: got %b, required 1", pop[1]); end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b0 || pop[1] !== 1'b0) begin
      errors++; $display("FAIL refill_gap: valid %b pop %b, required 0 0", ovalid[1], pop[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b1 || odata[1] !== 16'h00A1) begin
      errors++; $display("FAIL refill_word1: valid %b data %h, required valid 1 data 00a1", ovalid[1], odata[1]);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      checks++;
      if (ovalid[1] !== 1'b0 || pop[1] !== 1'b0) begin
        errors++; $display("FAIL refill_idle %0d: valid %b pop %b, required 0 0", j, ovalid[1], pop[1]);
      end
    end
    push_words(1, 16'h00A2, 1);
    @(negedge clk); #1;
    checks++;
    if (pop[1] !== 1'b1 || ovalid[1] !== 1'b0) begin
      errors++; $display("FAIL refill_pop2: pop %b valid %b, required pop 1 valid 0", pop[1], ovalid[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b0) begin errors++; $display("FAIL refill_lat2: valid %b, required 0", ovalid[1]); end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b1 || odata[1] !== 16'h00A2) begin
      errors++; $display("FAIL refill_word2: valid %b data %h, required valid 1 data 00a2", ovalid[1], odata[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[1] !== 1'b0) begin errors++; $display("FAIL refill_end: valid %b, required 0", ovalid[1]); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    ready = 4'b0100;
    push_words(2, 16'h0021, 4);
    @(negedge clk); #1;
    checks++;
    if (pop[2] !== 1'b1) begin errors++; $display("FAIL flush_pop1: got %b, required 1", pop[2]); end
    @(negedge clk); #1;
    checks++;
    if (pop[2] !== 1'b1) begin errors++; $display("FAIL flush_pop2: got %b, required 1", pop[2]); end
    @(negedge clk);
    flush = 4'b0100;
    #1;
    checks++;
    if (pop[2] !== 1'b0) begin errors++; $display("FAIL flush_cycle_pop: got %b, required 0", pop[2]); end
    @(negedge clk);
    flush = 4'b0000;
    #1;
    checks++;
    if (ovalid[2] !== 1'b0 || lvl[2] !== 3'd0 || pop[2] !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: valid %b level %0d pop %b, required valid 0 level 0 pop 1", ovalid[2], lvl[2], pop[2]);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      checks++;
      if (ovalid[2] !== 1'b0 || lvl[2] !== 3'd0) begin
        errors++; $display("FAIL flush_drop %0d: valid %b level %0d, required valid 0 level 0", j, ovalid[2], lvl[2]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[2] !== 1'b1 || odata[2] !== 16'h0023) begin
      errors++; $display("FAIL flush_word3: valid %b data %h, required valid 1 data 0023", ovalid[2], odata[2]);
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[2] !== 1'b1 || odata[2] !== 16'h0024) begin
      errors++; $display("FAIL flush_word4: valid %b data %h, required valid 1 data 0024", ovalid[2], odata[2]);
    end
    @(negedge clk); #1;
    checks++;
    if (ovalid[2] !== 1'b0) begin errors++; $display("FAIL flush_end: valid %b, required 0", ovalid[2]); end
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk); #1;
      done = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (fcount[k] != 0 || sbq[k].size() != 0 || ovalid[k]) done = 1'b0;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s_drain_timeout: drained %b, required 1", name, done); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ready = 4'b1111;
    for (int k = 0; k < 4; k++) push_words(k, 16'((k + 1) * 16'h0100), 16);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pop[k] !== 1'b0 || ovalid[k] !== 1'b0 || lvl[k] !== 3'd0) begin
        errors++;
        $display("FAIL rstmid_immediate lane %0d: pop %b valid %b level %0d, required 0 0 0", k, pop[k], ovalid[k], lvl[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain("rstmid");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pop[k] !== 1'b0 || lvl[k] !== 3'd0) begin
        errors++; $display("FAIL rstmid_idle lane %0d: pop %b level %0d, required 0 0", k, pop[k], lvl[k]);
      end
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    for (int k = 0; k < 4; k++) deliv[k] = 0;
    for (int k = 0; k < 4; k++) push_words(k, 16'((k + 1) * 16'h1000), 40);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      ready = 4'($urandom);
    end
    @(negedge clk);
    ready = 4'b1111;
    drain("random");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (deliv[k] !== 40) begin
        errors++; $display("FAIL random_count lane %0d: delivered %0d, required 40", k, deliv[k]);
      end
    end
    checks++;
    if (pop_empty !== 0) begin
      errors++; $display("FAIL pop_while_empty: seen %0d times, required 0", pop_empty);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_stream();
    test_backpressure();
    test_empty_refill();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
